// File: rtl/load_sched_pkg.sv
// Shared types and constants for the load scheduler and its FIFO.
package load_sched_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GUARD = 2'd2
  } sched_state_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/load_scheduler_if.sv
// Producer-side request channel for the load scheduler.
// Handshake: a transfer happens on a rising clk edge where req_valid_i && req_ready_o;
// req_val_i must stay stable while req_valid_i is high until that transfer.
interface load_scheduler_if #(parameter int CNT_W = 4);
  logic             req_valid_i;
  logic [CNT_W-1:0] req_val_i;
  logic             req_ready_o;

  modport master (output req_valid_i, output req_val_i, input req_ready_o);
  modport slave  (input req_valid_i, input req_val_i, output req_ready_o);
endinterface

// File: rtl/load_scheduler_sync_fifo.sv
// Registered FIFO with combinational head read and wrap-bit pointers.
module sync_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/load_scheduler.sv
// Queues counter load values and issues each as a one-cycle load pulse
// when the fed-back count reaches the terminal value.
module load_scheduler
  import load_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  load_scheduler_if.slave           req,
  input  logic [CNT_W-1:0]          term_i,
  input  logic [CNT_W-1:0]          count_i,
  output logic                      load_o,
  output logic [CNT_W-1:0]          load_val_o,
  output logic [ptr_w(DEPTH)-1:0]   fifo_cnt_o,
  output logic                      overflow_o,
  output sched_state_t              state_o
);
  sched_state_t     state_q, state_d;
  logic             load_d;
  logic [CNT_W-1:0] val_d;
  logic             push, pop, full, empty;
  logic [CNT_W-1:0] head;

  assign req.req_ready_o = !full;
  assign push            = req.req_valid_i && !full;
  assign state_o         = state_q;

  sync_fifo #(.W(CNT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req.req_val_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt_o)
  );

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    val_d   = load_val_o;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) state_d = ARMED;
      ARMED: begin
        if ((count_i == term_i) && !empty) begin
          load_d  = 1'b1;
          val_d   = head;
          pop     = 1'b1;
          state_d = GUARD;
        end
      end
      // One dead cycle lets the counter absorb the load before re-arming.
      GUARD: state_d = (!empty || push) ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      load_o     <= 1'b0;
      load_val_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_o     <= load_d;
      load_val_o <= val_d;
      overflow_o <= overflow_o | (req.req_valid_i && full);
    end
  end

endmodule

// File: tb/tb_load_scheduler.sv
// Directed self-checking bench for load_scheduler.
module tb_load_scheduler;
  import load_sched_pkg::*;

  logic             clk;
  logic             reset;
  logic [3:0]       term_i;
  logic [3:0]       count_i;
  logic             load_o;
  logic [3:0]       load_val_o;
  logic [2:0]       fifo_cnt_o;
  logic             overflow_o;
  sched_state_t     state_o;

  int tests = 0;
  int fails = 0;

  load_scheduler_if #(.CNT_W(4)) req_if ();

  load_scheduler #(.CNT_W(4), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req_if),
    .term_i     (term_i),
    .count_i    (count_i),
    .load_o     (load_o),
    .load_val_o (load_val_o),
    .fifo_cnt_o (fifo_cnt_o),
    .overflow_o (overflow_o),
    .state_o    (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [10:0] exp_load3;
  logic [3:0]  exp_val3 [11];

  initial begin
    reset              = 1'b1;
    req_if.req_valid_i = 1'b0;
    req_if.req_val_i   = 4'h0;
    term_i             = 4'h9;
    count_i            = 4'h0;
    step();
    reset = 1'b0;

    // Reset then idle 5 cycles
    repeat (5) step();
    check("rst_load",  {7'd0, load_o}, 8'd0);
    check("rst_val",   {4'd0, load_val_o}, 8'd0);
    check("rst_cnt",   {5'd0, fifo_cnt_o}, 8'd0);
    check("rst_ready", {7'd0, req_if.req_ready_o}, 8'd1);
    check("rst_ovf",   {7'd0, overflow_o}, 8'd0);
    check("rst_state", {6'd0, state_o}, {6'd0, IDLE});

    // Single value, count sweeping 0..15 against term 9
    req_if.req_valid_i = 1'b1;
    req_if.req_val_i   = 4'h3;
    step();
    req_if.req_valid_i = 1'b0;
    check("t2_cnt_after_push", {5'd0, fifo_cnt_o}, 8'd1);
    for (int c = 0; c < 16; c++) begin
      count_i = c[3:0];
      step();
      check("t2_load", {7'd0, load_o}, (c == 9) ? 8'd1 : 8'd0);
      if (c == 9) check("t2_val", {4'd0, load_val_o}, 8'h3);
    end
    check("t2_cnt_end", {5'd0, fifo_cnt_o}, 8'd0);
    check("t2_state_end", {6'd0, state_o}, {6'd0, IDLE});
    check("t2_val_hold", {4'd0, load_val_o}, 8'h3);

    // Three back-to-back pushes with the terminal match held
    term_i  = 4'hF;
    count_i = 4'hF;
    exp_load3 = 11'b00001010100;
    exp_val3  = '{4'h3, 4'h3, 4'h2, 4'h2, 4'h5, 4'h5, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
    for (int s = 0; s < 11; s++) begin
      if (s == 0) begin req_if.req_valid_i = 1'b1; req_if.req_val_i = 4'h2; end
      if (s == 1) req_if.req_val_i = 4'h5;
      if (s == 2) req_if.req_val_i = 4'hA;
      if (s == 3) req_if.req_valid_i = 1'b0;
      step();
      check("t3_load", {7'd0, load_o}, {7'd0, exp_load3[s]});
      check("t3_val",  {4'd0, load_val_o}, {4'd0, exp_val3[s]});
    end
    req_if.req_valid_i = 1'b0;
    check("t3_cnt_end", {5'd0, fifo_cnt_o}, 8'd0);

    // Overfill with no terminal match
    do_reset();
    term_i  = 4'h9;
    count_i = 4'h0;
    for (int i = 0; i < 5; i++) begin
      req_if.req_valid_i = 1'b1;
      req_if.req_val_i   = 4'(i + 1);
      #1;
      check("t4_ready", {7'd0, req_if.req_ready_o}, (i < 4) ? 8'd1 : 8'd0);
      check("t4_ovf_pre", {7'd0, overflow_o}, 8'd0);
      step();
    end
    req_if.req_valid_i = 1'b0;
    check("t4_cnt", {5'd0, fifo_cnt_o}, 8'd4);
    check("t4_ovf", {7'd0, overflow_o}, 8'd1);
    repeat (3) step();
    check("t4_ovf_sticky", {7'd0, overflow_o}, 8'd1);
    check("t4_load_none", {7'd0, load_o}, 8'd0);

    // Full FIFO, match and new request in the same cycle
    do_reset();
    check("t5_ovf_clr", {7'd0, overflow_o}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      req_if.req_valid_i = 1'b1;
      req_if.req_val_i   = 4'(i + 1);
      step();
    end
    req_if.req_val_i = 4'h7;
    count_i          = 4'h9;
    #1;
    check("t5_ready_full", {7'd0, req_if.req_ready_o}, 8'd0);
    check("t5_state_armed", {6'd0, state_o}, {6'd0, ARMED});
    step();
    req_if.req_valid_i = 1'b0;
    count_i            = 4'h0;
    check("t5_load", {7'd0, load_o}, 8'd1);
    check("t5_val",  {4'd0, load_val_o}, 8'h1);
    check("t5_cnt",  {5'd0, fifo_cnt_o}, 8'd3);
    check("t5_ovf",  {7'd0, overflow_o}, 8'd1);
    check("t5_state_guard", {6'd0, state_o}, {6'd0, GUARD});
    step();
    check("t5_load_off", {7'd0, load_o}, 8'd0);
    check("t5_rearmed", {6'd0, state_o}, {6'd0, ARMED});

    // Reset coincident with a terminal match while armed
    count_i = 4'h9;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    check("t6_load", {7'd0, load_o}, 8'd0);
    check("t6_val",  {4'd0, load_val_o}, 8'd0);
    check("t6_cnt",  {5'd0, fifo_cnt_o}, 8'd0);
    check("t6_ovf",  {7'd0, overflow_o}, 8'd0);
    check("t6_state", {6'd0, state_o}, {6'd0, IDLE});
    step();
    check("t6_load_after", {7'd0, load_o}, 8'd0);
    check("t6_ready", {7'd0, req_if.req_ready_o}, 8'd1);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
